// File: rtl/serial_t.sv
// serial_t: MSB-first serial transmitter with start bit, 8 data bits and stop bit(s).
// Define SERIAL_T_STOP2_EN to send two stop bits instead of one.
module serial_t #(
   parameter int BIT_CYCLES = 5201
) (
   input  logic       m_clock,
   input  logic       _proc_start_reset,
   input  logic [7:0] DATA,
   input  logic       launch,
   output logic       TXD,
   output logic       busy,
   output logic       complete
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [15:0] LAST     = 16'(BIT_CYCLES - 1);
   localparam logic [15:0] PRE_LAST = 16'(BIT_CYCLES - 2);

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shreg;
   logic        last_stop;

`ifdef SERIAL_T_STOP2_EN
   logic stop_sec;
   assign last_stop = stop_sec;
`else
   assign last_stop = 1'b1;
`endif

   assign busy = (state != S_IDLE);

   // TXD is loaded with the level of the bit that starts on this edge.
   always_ff @(posedge m_clock or posedge _proc_start_reset) begin
      if (_proc_start_reset) begin
         state    <= S_IDLE;
         TXD      <= 1'b1;
         complete <= 1'b0;
         cnt      <= 16'd0;
         idx      <= 3'd0;
         shreg    <= 8'h00;
`ifdef SERIAL_T_STOP2_EN
         stop_sec <= 1'b0;
`endif
      end else begin
         complete <= 1'b0;
         case (state)
            S_IDLE: begin
               if (launch) begin
                  shreg <= DATA;
                  cnt   <= 16'd0;
                  idx   <= 3'd0;
                  TXD   <= 1'b0;
                  state <= S_START;
               end
            end
            S_START: begin
               if (cnt == LAST) begin
                  cnt   <= 16'd0;
                  TXD   <= shreg[7];
                  state <= S_DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (cnt == LAST) begin
                  cnt <= 16'd0;
                  if (idx == 3'd7) begin
                     TXD   <= 1'b1;
                     state <= S_STOP;
`ifdef SERIAL_T_STOP2_EN
                     stop_sec <= 1'b0;
`endif
                  end else begin
                     idx   <= idx + 3'd1;
                     shreg <= {shreg[6:0], 1'b0};
                     TXD   <= shreg[6];
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (cnt == LAST) begin
                  cnt <= 16'd0;
                  if (last_stop) state <= S_IDLE;
`ifdef SERIAL_T_STOP2_EN
                  else stop_sec <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 16'd1;
                  // Registered pulse lands on the final cycle of the last stop bit.
                  if (cnt == PRE_LAST && last_stop) complete <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_t.sv
// Directed bench for serial_t: table of frames plus reset, launch-ignore and long-period sequences.
module tb_serial_t;

   localparam int BC = 4;
   localparam int BB = 5201;
`ifdef SERIAL_T_STOP2_EN
   localparam int NS = 2;
`else
   localparam int NS = 1;
`endif
   localparam int NF = (9 + NS) * BC;
   localparam int NB = (9 + NS) * BB;

   logic       m_clock = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data = 8'h00;
   logic       launch = 1'b0;
   logic       txd, busy, complete;
   logic [7:0] data_b = 8'h00;
   logic       launch_b = 1'b0;
   logic       txd_b, busy_b, complete_b;

   int checks = 0;
   int failures = 0;

   serial_t #(.BIT_CYCLES(BC)) u_dut (
      .m_clock(m_clock), ._proc_start_reset(rst), .DATA(data), .launch(launch),
      .TXD(txd), .busy(busy), .complete(complete));

   serial_t u_big (
      .m_clock(m_clock), ._proc_start_reset(rst), .DATA(data_b), .launch(launch_b),
      .TXD(txd_b), .busy(busy_b), .complete(complete_b));

   initial forever begin
      #5;
      if (clk_en) m_clock = ~m_clock;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge m_clock);
      #1;
   endtask

   // Launch d (accepted on the next edge) and check every cycle of the frame.
   task automatic run_frame(input logic [7:0] d, input logic [9:0] pat, input int inj1, input int inj2);
      int bi;
      logic e;
      data = d;
      launch = 1'b1;
      step();
      for (int k = 1; k <= NF; k++) begin
         if (k == inj1 || k == inj2) begin
            launch = 1'b1;
            data = 8'hFF;
         end else begin
            launch = 1'b0;
            data = 8'($urandom);
         end
         bi = (k - 1) / BC;
         e = (bi < 10) ? pat[9 - bi] : 1'b1;
         chk($sformatf("txd[%02h] k=%0d", d, k), int'(txd), int'(e));
         chk($sformatf("busy[%02h] k=%0d", d, k), int'(busy), 1);
         chk($sformatf("complete[%02h] k=%0d", d, k), int'(complete), (k == NF) ? 1 : 0);
         step();
      end
      launch = 1'b0;
      chk($sformatf("idle_busy[%02h]", d), int'(busy), 0);
      chk($sformatf("idle_txd[%02h]", d), int'(txd), 1);
      chk($sformatf("idle_complete[%02h]", d), int'(complete), 0);
   endtask

   typedef struct {
      logic [7:0] d;
      logic [9:0] pat;
      int         inj1;
      int         inj2;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int zeros, compk, ncomp, hi_err, comp_seen;

      // {byte, start+data+stop levels in line order, launch-injection cycles}
      vecs[0] = '{8'hA5, 10'b0101001011, 0, 0};
      vecs[1] = '{8'h3C, 10'b0001111001, 5, 39};
      vecs[2] = '{8'hFF, 10'b0111111111, 3, NF};
      vecs[3] = '{8'h00, 10'b0000000001, 0, 0};
      vecs[4] = '{8'h55, 10'b0010101011, 12, 0};
      vecs[5] = '{8'h81, 10'b0100000011, 0, 0};

      // Reset with no clock running.
      #2 rst = 1'b1;
      #2;
      chk("rst_txd", int'(txd), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_complete", int'(complete), 0);
      chk("rst_big_txd", int'(txd_b), 1);
      chk("rst_big_busy", int'(busy_b), 0);
      clk_en = 1'b1;
      repeat (3) @(posedge m_clock);
      @(negedge m_clock) rst = 1'b0;
      step();

      // 0x3C and 0xFF run back to back so the second launch lands in the first idle cycle.
      for (int i = 0; i < 6; i++)
         run_frame(vecs[i].d, vecs[i].pat, vecs[i].inj1, vecs[i].inj2);

      // Reset mid-frame of 0x81.
      data = 8'h81;
      launch = 1'b1;
      step();
      launch = 1'b0;
      repeat (16) step();
      chk("pre_rst_txd", int'(txd), 0);
      chk("pre_rst_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_txd", int'(txd), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_complete", int'(complete), 0);
      comp_seen = 0;
      repeat (2) begin
         @(posedge m_clock);
         #1;
         if (complete) comp_seen++;
      end
      @(negedge m_clock) rst = 1'b0;
      comp_seen += int'(complete);
      chk("rst_no_complete", comp_seen, 0);
      run_frame(8'h81, 10'b0100000011, 0, 0);

      // Default period, all-zero byte.
      data_b = 8'h00;
      launch_b = 1'b1;
      step();
      launch_b = 1'b0;
      zeros = 0; compk = 0; ncomp = 0; hi_err = 0;
      for (int k = 1; k <= NB; k++) begin
         if (txd_b == 1'b0) zeros++;
         if (k > 9 * BB && txd_b !== 1'b1) hi_err++;
         if (complete_b) begin
            ncomp++;
            compk = k;
         end
         step();
      end
      chk("big_low_cycles", zeros, 46809);
      chk("big_high_err", hi_err, 0);
      chk("big_complete_count", ncomp, 1);
      chk("big_complete_cycle", compk, NB);
      chk("big_busy_after", int'(busy_b), 0);
      chk("big_txd_after", int'(txd_b), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_t.md
SERIAL_T -- requirements
Module: serial_t

Interface
REQ-001 SHALL provide parameter BIT_CYCLES, default 5201, clock cycles per serial bit; legal range 2..65536.
REQ-002 SHALL provide port m_clock, input, 1, rising-edge clock.
REQ-003 SHALL provide port _proc_start_reset, input, 1, reset (asynchronous, active-high).
REQ-004 SHALL provide port DATA, input, 8, byte to transmit, sampled only in the launch-accept cycle.
REQ-005 SHALL provide port launch, input, 1, transmit request strobe.
REQ-006 SHALL provide port TXD, output, 1, serial line; idles high.
REQ-007 SHALL provide port busy, output, 1, high while a frame is in progress.
REQ-008 SHALL provide port complete, output, 1, one-cycle pulse marking the end of a frame.

Function
REQ-009 SHALL implement states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-010 SHALL accept launch only in IDLE: latch DATA into an 8-bit shift register, clear the bit counter and index, and enter START next edge.
REQ-011 SHALL ignore launch in START, DATA and STOP; no queuing, latched byte unchanged.
REQ-012 SHALL drive TXD registered: 1 in IDLE, 0 in START, current shift-register MSB in DATA, 1 in STOP.
REQ-013 SHALL send data MSB first (bit7 .. bit0), shifting left once per bit period.
REQ-014 SHALL hold each bit for exactly BIT_CYCLES cycles using a 16-bit counter 0..BIT_CYCLES-1; counter clears on each bit boundary, never wraps past BIT_CYCLES-1.
REQ-015 SHALL use a 3-bit index in DATA; leave DATA for STOP when index = 7 and counter = BIT_CYCLES-1.
REQ-016 SHALL assert complete for exactly one cycle, the last cycle of STOP (counter = BIT_CYCLES-1); busy still high in that cycle.
REQ-017 SHALL return to IDLE on the edge after complete; launch during the complete cycle is ignored; launch in the first IDLE cycle is accepted.
REQ-018 Frame timing: TXD falls on the edge following the accept cycle; frame occupies 10*BIT_CYCLES cycles (11*BIT_CYCLES with REQ-023).
REQ-019 DATA changes while busy SHALL NOT affect the frame in progress.

Reset
REQ-020 SHALL, on _proc_start_reset high, immediately force state IDLE, TXD=1, busy=0, complete=0, counter=0, index=0, shift register=0x00, independent of m_clock.
REQ-021 SHALL abort any frame on reset mid-operation, with no complete pulse; launch is accepted on the first edge after reset deasserts.

Configuration
REQ-022 Macro SERIAL_T_STOP2_EN SHALL select the stop-bit count.
REQ-023 With SERIAL_T_STOP2_EN defined: STOP lasts 2*BIT_CYCLES cycles (two stop bits); complete is in its final cycle.
REQ-024 Without SERIAL_T_STOP2_EN: one stop bit of BIT_CYCLES cycles; no extra logic.

Verification
REQ-025 Reset: assert _proc_start_reset with no clock -> TXD=1, busy=0, complete=0 immediately.
REQ-026 BIT_CYCLES=4, DATA=0xA5, launch pulse -> TXD 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; complete one cycle, 40 cycles after TXD falls minus one; busy low next cycle.
REQ-027 Default BIT_CYCLES=5201, DATA=0x00 -> TXD low for 9*5201=46809 cycles, then high 5201; complete at cycle 52010 after accept.
REQ-028 BIT_CYCLES=4, launch 0x3C, then launch 0xFF with DATA=0xFF at cycles 5 and 39 after accept -> only 0x3C transmitted; launch in first IDLE cycle starts 0xFF frame.
REQ-029 BIT_CYCLES=4, reset pulse at cycle 17 of a 0x81 frame -> TXD=1 same cycle, no complete; subsequent launch 0x81 transmits cleanly.
REQ-030 SERIAL_T_STOP2_EN defined, BIT_CYCLES=4, DATA=0x55 -> stop high for 8 cycles; complete at 44th frame cycle.
